// File: rtl/pinv_row_mac.sv
// Serial dot product of one pseudoinverse row with a latched measurement vector.
// Each request produces one signed result after N_COEF single-cycle MAC steps.
module pinv_row_mac #(
    parameter int unsigned N_ROWS = 99,
    parameter int unsigned ROW_W  = 384,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned Y_W    = 12,
    parameter int unsigned N_COEF = ROW_W / COEF_W,
    parameter int unsigned ACC_W  = COEF_W + Y_W + $clog2(ROW_W / COEF_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_ROWS*ROW_W-1:0]  pinv,
    input  logic                     start,
    input  logic [6:0]               row_sel,
    input  logic [N_COEF*Y_W-1:0]    y_vec,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ACC_W-1:0]         result
);

    localparam int unsigned K_W    = $clog2(N_COEF);
    localparam int unsigned PROD_W = COEF_W + Y_W;

    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ROW_W-1:0]        row_q;
    logic [N_COEF*Y_W-1:0]   y_q;
    logic signed [ACC_W-1:0] acc;
    logic [K_W-1:0]          k;

    logic                    sel_ok;
    logic                    last;
    logic signed [COEF_W-1:0] coef;
    logic signed [Y_W-1:0]    y_k;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;

    assign sel_ok = 32'(row_sel) < N_ROWS;
    assign last   = (k == K_W'(N_COEF - 1));

    // Row and vector are shifted down each step, so element k always sits at bit 0.
    assign coef     = row_q[COEF_W-1:0];
    assign y_k      = y_q[Y_W-1:0];
    assign prod     = PROD_W'(coef) * PROD_W'(y_k);
    assign prod_ext = ACC_W'(prod);
    assign sum      = acc + prod_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start && sel_ok) state_nxt = MAC;
            MAC:  if (last)            state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state == MAC) busy = 1'b1;
    end

    // Datapath and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q  <= '0;
            y_q    <= '0;
            acc    <= '0;
            k      <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (sel_ok) begin
                            row_q <= pinv[32'(row_sel) * ROW_W +: ROW_W];
                            y_q   <= y_vec;
                            acc   <= '0;
                            k     <= '0;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc   <= sum;
                    k     <= k + K_W'(1);
                    row_q <= row_q >> COEF_W;
                    y_q   <= y_q >> Y_W;
                    if (last) begin
                        result <= sum;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pinv_row_mac.sv
// Directed bench for pinv_row_mac: a request-level reference model checked every
// cycle, plus hand-computed expectations for the synthetic rows and error cases.
module tb_pinv_row_mac;

    localparam int NR = 99;
    localparam int RW = 384;
    localparam int CW = 8;
    localparam int YW = 12;
    localparam int NC = 48;
    localparam int AW = 26;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR*RW-1:0]     pinv;
    logic                 start;
    logic [6:0]           row_sel;
    logic [NC*YW-1:0]     y_vec;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [AW-1:0]        result;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    pinv_row_mac dut (
        .clk     (clk),
        .rst     (rst),
        .pinv    (pinv),
        .start   (start),
        .row_sel (row_sel),
        .y_vec   (y_vec),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [AW-1:0] dot(input int r, input logic [NC*YW-1:0] y);
        int s = 0;
        for (int k = 0; k < NC; k++) begin
            s += int'($signed(pinv[r*RW + k*CW +: CW])) * int'($signed(y[k*YW +: YW]));
        end
        return AW'(s);
    endfunction

    // Request-level model: a pending result is released NC edges after acceptance.
    int rem;
    logic m_done, m_err;
    logic signed [AW-1:0] m_result, pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= 0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            m_result <= '0;
            pend     <= '0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (rem != 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    m_done   <= 1'b1;
                    m_result <= pend;
                end
            end else if (start) begin
                if (int'(row_sel) < NR) begin
                    pend <= dot(int'(row_sel), y_vec);
                    rem  <= NC;
                end else begin
                    m_done <= 1'b1;
                    m_err  <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   longint'(busy), longint'(rem != 0));
            check("done",   longint'(done), longint'(m_done));
            check("err",    longint'(err),  longint'(m_err));
            check("result", longint'($signed(result)), longint'(m_result));
        end
    end

    // Called just after the acceptance edge; returns edges until done and busy cycles.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int r, input logic [NC*YW-1:0] y, output int n, output int bc);
        @(negedge clk);
        start   = 1'b1;
        row_sel = 7'(r);
        y_vec   = y;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
    endtask

    logic [NC*YW-1:0] y1, y7ff, yr, ya, yb;
    logic signed [AW-1:0] last_exp;
    int n, bc, dcnt, r;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        row_sel = '0;
        y_vec   = '0;
        for (int i = 0; i < NR*RW/32; i++) pinv[i*32 +: 32] = $urandom;
        for (int k = 0; k < NC; k++) begin
            pinv[5*RW + k*CW +: CW]  = 8'h01;
            pinv[98*RW + k*CW +: CW] = 8'h80;
            y1[k*YW +: YW]   = 12'd1;
            y7ff[k*YW +: YW] = 12'h7FF;
        end

        repeat (3) @(negedge clk);
        check("rst_busy",   longint'(busy), 0);
        check("rst_done",   longint'(done), 0);
        check("rst_err",    longint'(err), 0);
        check("rst_result", longint'(result), 0);
        chk_en = 1'b1;
        rst    = 1'b0;

        run_op(5, y1, n, bc);
        check("row5_latency", longint'(n), 48);
        check("row5_busy_cycles", longint'(bc), 48);
        check("row5_result", longint'($signed(result)), 48);
        check("row5_err", longint'(err), 0);

        run_op(98, y7ff, n, bc);
        check("row98_result", longint'($signed(result)), -12576768);
        check("row98_latency", longint'(n), 48);

        for (int k = 0; k < NC; k++) yr[k*YW +: YW] = 12'(k - 24);
        run_op(0, yr, n, bc);
        check("row0_result", longint'($signed(result)), longint'(dot(0, yr)));

        for (int t = 0; t < 20; t++) begin
            r = int'($urandom_range(0, NR - 1));
            for (int k = 0; k < NC; k++) yr[k*YW +: YW] = 12'($urandom);
            run_op(r, yr, n, bc);
            last_exp = dot(r, yr);
            check("rand_result", longint'($signed(result)), longint'(last_exp));
            check("rand_latency", longint'(n), 48);
        end

        // Out-of-range rows: one-cycle done+err, result untouched.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start   = 1'b1;
            row_sel = (t == 0) ? 7'd99 : 7'd127;
            @(negedge clk);
            start = 1'b0;
            check("bad_done", longint'(done), 1);
            check("bad_err",  longint'(err), 1);
            check("bad_busy", longint'(busy), 0);
            check("bad_result_held", longint'($signed(result)), longint'(last_exp));
            @(negedge clk);
            check("bad_done_pulse", longint'(done), 0);
            check("bad_err_pulse",  longint'(err), 0);
        end

        // start during MAC and input changes must not disturb the operation in flight.
        for (int k = 0; k < NC; k++) begin
            ya[k*YW +: YW] = 12'($urandom);
            yb[k*YW +: YW] = 12'($urandom);
        end
        @(negedge clk);
        start   = 1'b1;
        row_sel = 7'd3;
        y_vec   = ya;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        dcnt  = 0;
        while (n < 48) begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                start   = 1'b1;
                row_sel = 7'd7;
                y_vec   = yb;
            end
            if (n == 11) start = 1'b0;
            if (done) dcnt++;
        end
        check("midop_done_count", longint'(dcnt), 1);
        check("midop_done_at_48", longint'(done), 1);
        check("midop_result", longint'($signed(result)), longint'(dot(3, ya)));
        start   = 1'b1;
        row_sel = 7'd9;
        y_vec   = yb;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        check("b2b_latency", longint'(n), 48);
        check("b2b_result", longint'($signed(result)), longint'(dot(9, yb)));

        // Asynchronous reset mid-operation.
        run_op(11, ya, n, bc);
        @(negedge clk);
        start   = 1'b1;
        row_sel = 7'd11;
        y_vec   = yb;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   longint'(busy), 0);
        check("arst_done",   longint'(done), 0);
        check("arst_err",    longint'(err), 0);
        check("arst_result", longint'(result), 0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("arst_no_done", longint'(dcnt), 0);
        run_op(12, yb, n, bc);
        check("post_rst_latency", longint'(n), 48);
        check("post_rst_result", longint'($signed(result)), longint'(dot(12, yb)));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
